// File: rtl/clkdiv_cfg_ctrl_if.sv
// Requester-side bundle for the clock-divider reconfiguration controller:
// two level requests with their ratios and the matching completion pulses.
interface clkdiv_cfg_ctrl_if;
  // Handshake: a requester raises i_reqN with a stable i_ratioN and holds it
  // until the controller returns a one-cycle o_ackN. It drops i_reqN in the
  // cycle after the ack. i_ratioN is sampled only at the grant edge. A request
  // still high while the controller is idle is taken as a fresh request.
  logic       i_req0;
  logic [4:0] i_ratio0;
  logic       i_req1;
  logic [4:0] i_ratio1;
  logic       o_ack0;
  logic       o_ack1;

  modport master (
    output i_req0,
    output i_ratio0,
    output i_req1,
    output i_ratio1,
    input  o_ack0,
    input  o_ack1
  );

  modport slave (
    input  i_req0,
    input  i_ratio0,
    input  i_req1,
    input  i_ratio1,
    output o_ack0,
    output o_ack1
  );
endinterface

// File: rtl/clkdiv_cfg_ctrl.sv
// Glitch-safe divide-ratio reconfiguration controller with a two-way round-robin
// front end. Optional macro CLKDIV_CTRL_SKIP_EN acks same-ratio requests at once.
module clkdiv_cfg_ctrl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned LOCK_CYC   = 8,
  parameter logic [4:0]  RST_RATIO  = 5'd1
) (
  input  logic              i_ref_clk,
  input  logic              i_rst_n,
  clkdiv_cfg_ctrl_if.slave  req_if,
  output logic [4:0]        o_div_ratio,
  output logic              o_clk_en,
  output logic              o_busy,
  output logic              o_grant_id,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LOAD   = 3'd2,
    S_LOCK   = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] held_ratio;
  logic       req_any;
  logic       pick;
  logic [4:0] pick_ratio;

  // o_grant_id doubles as the round-robin pointer: on a tie the other side wins.
  always_comb begin
    req_any    = req_if.i_req0 | req_if.i_req1;
    pick       = (req_if.i_req0 & req_if.i_req1) ? ~o_grant_id : req_if.i_req1;
    pick_ratio = pick ? req_if.i_ratio1 : req_if.i_ratio0;
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      held_ratio    <= RST_RATIO;
      o_div_ratio   <= RST_RATIO;
      o_clk_en      <= 1'b1;
      o_busy        <= 1'b0;
      o_grant_id    <= 1'b1;
      req_if.o_ack0 <= 1'b0;
      req_if.o_ack1 <= 1'b0;
    end else begin
      req_if.o_ack0 <= 1'b0;
      req_if.o_ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            o_grant_id <= pick;
            held_ratio <= pick_ratio;
            cnt        <= 4'd0;
            o_busy     <= 1'b1;
`ifdef CLKDIV_CTRL_SKIP_EN
            if (pick_ratio == o_div_ratio) begin
              state         <= S_ACK;
              req_if.o_ack0 <= ~pick;
              req_if.o_ack1 <= pick;
            end else begin
              state    <= S_SETTLE;
              o_clk_en <= 1'b0;
            end
`else
            state    <= S_SETTLE;
            o_clk_en <= 1'b0;
`endif
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state       <= S_LOAD;
            cnt         <= 4'd0;
            o_div_ratio <= held_ratio;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_LOAD: begin
          state    <= S_LOCK;
          cnt      <= 4'd0;
          o_clk_en <= 1'b1;
        end

        // Ack is launched on the LOCK->ACK edge so it is high for the ACK cycle only.
        S_LOCK: begin
          if (cnt == LOCK_LAST) begin
            state         <= S_ACK;
            cnt           <= 4'd0;
            req_if.o_ack0 <= ~o_grant_id;
            req_if.o_ack1 <= o_grant_id;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_ACK: begin
          state  <= S_IDLE;
          cnt    <= 4'd0;
          o_busy <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          cnt      <= 4'd0;
          o_busy   <= 1'b0;
          o_clk_en <= 1'b1;
        end
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Scoreboard bench for clkdiv_cfg_ctrl: driver plans expected completions from
// the timing rules, a negedge monitor compares every cycle against the plan.
module tb_clkdiv_cfg_ctrl;

  localparam int         SETTLE = 4;
  localparam int         LOCK   = 8;
  localparam logic [4:0] RSTR   = 5'd1;
  localparam int         W      = 23;

  logic       clk;
  logic       rst_n;
  logic [4:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       grant_id;
  logic [2:0] dbg_state;

  clkdiv_cfg_ctrl_if bus ();

  clkdiv_cfg_ctrl #(
    .SETTLE_CYC (SETTLE),
    .LOCK_CYC   (LOCK),
    .RST_RATIO  (RSTR)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .req_if      (bus.slave),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_grant_id  (grant_id),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // entry: {id, ratio[4:0], skip, ack_cycle[15:0]}
  logic [W-1:0] exp_q[$];
  int         vecs = 0;
  int         fails = 0;
  bit         mon_on = 1'b0;
  logic [4:0] model_ratio = RSTR;
  logic [4:0] plan_ratio = RSTR;
  bit         m_last = 1'b1;
  bit         mon_gid = 1'b1;

  function automatic logic [W-1:0] mk(input bit id, input logic [4:0] r, input bit sk, input int a);
    logic [15:0] a16;
    a16 = a[15:0];
    return {id, r, sk, a16};
  endfunction

  function automatic int dur(input bit sk);
    return sk ? 1 : SETTLE + LOCK + 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: grant order from round-robin rules, completion cycle
  // from the sequence length; a same-ratio request short-circuits if enabled.
  task automatic plan(input bit r0, input bit r1, input logic [4:0] a0, input logic [4:0] a1, input int g);
    bit ids[2];
    int n;
    int gg;
    bit id;
    bit sk;
    logic [4:0] r;
    n = 0;
    if (r0 && r1) begin
      ids[0] = ~m_last;
      ids[1] = m_last;
      n = 2;
    end else if (r0) begin
      ids[0] = 1'b0;
      n = 1;
    end else if (r1) begin
      ids[0] = 1'b1;
      n = 1;
    end
    gg = g;
    for (int i = 0; i < n; i++) begin
      id = ids[i];
      r  = id ? a1 : a0;
      sk = 1'b0;
`ifdef CLKDIV_CTRL_SKIP_EN
      sk = (r == plan_ratio);
`endif
      exp_q.push_back(mk(id, r, sk, gg + dur(sk)));
      plan_ratio = r;
      m_last     = id;
      gg         = gg + dur(sk) + 1;
    end
  endtask

  // driver: raise requests, drop each on its ack, optional mid-flight events
  task automatic run_txn(input bit r0, input bit r1, input logic [4:0] a0, input logic [4:0] a1,
                         input int chg_at, input logic [4:0] chg_val, input int rst_at);
    int g;
    int t;
    g = cyc;
    bus.i_req0   = r0;
    bus.i_req1   = r1;
    bus.i_ratio0 = a0;
    bus.i_ratio1 = a1;
    plan(r0, r1, a0, a1, g);
    t = 0;
    while ((bus.i_req0 || bus.i_req1) && t < 200) begin
      tick();
      t++;
      if (chg_at > 0 && cyc == g + chg_at) bus.i_ratio0 = chg_val;
      if (rst_at > 0 && cyc == g + rst_at) rst_n = 1'b0;
      if (rst_at > 0 && cyc == g + rst_at + 1) begin
        rst_n = 1'b1;
        exp_q.delete();
        model_ratio = RSTR;
        plan_ratio  = RSTR;
        m_last      = 1'b1;
        mon_gid     = 1'b1;
        plan(bus.i_req0, bus.i_req1, bus.i_ratio0, bus.i_ratio1, cyc);
      end
      if (bus.o_ack0) bus.i_req0 = 1'b0;
      if (bus.o_ack1) bus.i_req1 = 1'b0;
    end
    if (t >= 200) begin
      chk("ack_timeout", 32'(t), 32'd0);
      bus.i_req0 = 1'b0;
      bus.i_req1 = 1'b0;
      exp_q.delete();
    end
    tick();
  endtask

  // monitor: every cycle, derive expected outputs from the head of the queue
  initial begin
    logic [W-1:0] h;
    bit           inw;
    bit           hid;
    bit           hsk;
    logic [4:0]   hr;
    int           a;
    int           g;
    logic         e_busy;
    logic         e_en;
    logic [4:0]   e_ratio;
    logic         e_ack;
    logic         e_gid;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        e_busy  = 1'b0;
        e_en    = 1'b1;
        e_ratio = model_ratio;
        e_ack   = 1'b0;
        e_gid   = mon_gid;
        hid     = 1'b0;
        hr      = model_ratio;
        if (exp_q.size() > 0) begin
          h   = exp_q[0];
          hid = h[22];
          hr  = h[21:17];
          hsk = h[16];
          a   = int'(h[15:0]);
          g   = a - dur(hsk);
          inw = (cyc > g) && (cyc <= a);
          if (inw) begin
            e_busy = 1'b1;
            e_gid  = hid;
            e_en   = hsk || (cyc >= g + SETTLE + 2);
            if (!hsk && cyc >= g + SETTLE + 1) e_ratio = hr;
          end
          e_ack = (cyc == a);
        end
        chk("busy",      32'(busy),      32'(e_busy));
        chk("clk_en",    32'(clk_en),    32'(e_en));
        chk("div_ratio", 32'(div_ratio), 32'(e_ratio));
        chk("grant_id",  32'(grant_id),  32'(e_gid));
        chk("ack0",      32'(bus.o_ack0), 32'(e_ack && !hid));
        chk("ack1",      32'(bus.o_ack1), 32'(e_ack && hid));
        if (e_ack) begin
          void'(exp_q.pop_front());
          model_ratio = hr;
          mon_gid     = hid;
        end
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  // stimulus
  initial begin
    logic [4:0] ra;
    logic [4:0] rb;
    int         pat;
    rst_n        = 1'b0;
    bus.i_req0   = 1'b0;
    bus.i_req1   = 1'b0;
    bus.i_ratio0 = 5'd0;
    bus.i_ratio1 = 5'd0;
    tick();
    mon_on = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    run_txn(1'b1, 1'b0, 5'd6, 5'd0, 0, 5'd0, 0);
    run_txn(1'b1, 1'b0, 5'd6, 5'd0, 0, 5'd0, 0);
    run_txn(1'b1, 1'b1, 5'd4, 5'd8, 0, 5'd0, 0);
    run_txn(1'b1, 1'b1, 5'd4, 5'd8, 0, 5'd0, 0);
    run_txn(1'b1, 1'b0, 5'd6, 5'd0, 3, 5'd9, 0);
    run_txn(1'b0, 1'b1, 5'd0, 5'd3, 0, 5'd0, 7);
    run_txn(1'b1, 1'b0, 5'd0, 5'd0, 0, 5'd0, 0);
    run_txn(1'b0, 1'b1, 5'd0, 5'd1, 0, 5'd0, 0);

    for (int i = 0; i < 30; i++) begin
      pat = $urandom_range(1, 3);
      ra  = 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = plan_ratio;
      if ($urandom_range(0, 3) == 0) rb = plan_ratio;
      run_txn(pat[0], pat[1], ra, rb, 0, 5'd0, 0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
